// File: rtl/jedro_1_test_ctrl_pkg.sv
// jedro_1_test_ctrl_pkg: register word offsets, HALT bit index and byte-lane merge helper
package jedro_1_test_ctrl_pkg;
  localparam logic [5:0] OFF_SIG_START = 6'h00;
  localparam logic [5:0] OFF_SIG_END   = 6'h01;
  localparam logic [5:0] OFF_HALT      = 6'h02;
  localparam logic [5:0] OFF_CYCLE_LO  = 6'h03;
  localparam logic [5:0] OFF_CYCLE_HI  = 6'h04;
  localparam logic [5:0] OFF_CONSOLE   = 6'h05;
  localparam int HALT_BIT = 0;

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wdata,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i+:8] = be[i] ? wdata[8*i+:8] : old[8*i+:8];
    return res;
  endfunction
endpackage

// File: rtl/jedro_1_sync_fifo.sv
// jedro_1_sync_fifo: synchronous FIFO, drops pushes when full, ignores pops when empty
//   push_i/wdata_i write side, pop_i read side, rdata_o = head entry (from registers),
//   full_o/empty_o/count_o occupancy; async active-low reset clears storage and pointers.
module jedro_1_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full_o  = count_o == (AW+1)'(DEPTH);
  assign empty_o = count_o == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr];
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count_o <= count_o + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/jedro_1_test_ctrl.sv
// jedro_1_test_ctrl: memory-mapped test-control responder (signature regs, halt, cycle counter, console)
//   Request: req_i, we_i (0 = read), addr_i, wdata_i; always accepted.
//   Response one cycle later: rvalid_o / wvalid_o pulse, err_o and rdata_o qualify it.
//   Status: halt_o (sticky), sig_start_o, sig_end_o.
//   Console: cons_valid_o/cons_data_o/cons_ready_i byte stream out of the TX FIFO.
//   Macro JEDRO_1_TEST_CTRL_CONSOLE_EN enables the console FIFO; without it CONSOLE accesses error
//   and the console outputs are tied to 0.
module jedro_1_test_ctrl
  import jedro_1_test_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  wvalid_o,
  output logic                  err_o,
  output logic                  halt_o,
  output logic [31:0]           sig_start_o,
  output logic [31:0]           sig_end_o,
  output logic                  cons_valid_o,
  output logic [7:0]            cons_data_o,
  input  logic                  cons_ready_i
);
  if (DATA_WIDTH != 32 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BASE_ADDR[7:0] != 8'h00) begin : g_bad_cfg
    $error("jedro_1_test_ctrl: unsupported parameter set");
  end
  logic hit, rd, wr, err_c, cons_err, unused_addr;
  logic [5:0] off, last_off;
  logic [31:0] rd_c, cons_st, snap_q;
  logic [63:0] cycle_q;
  assign hit = addr_i[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8];
  assign off = addr_i[7:2];
  assign rd  = we_i == '0;
  assign wr  = req_i && hit && !rd;
  assign unused_addr = ^addr_i[1:0];
`ifdef JEDRO_1_TEST_CTRL_CONSOLE_EN
  localparam int CNT_W = $clog2(FIFO_DEPTH);
  logic push, full, empty;
  logic [CNT_W:0] count;
  assign push = wr && off == OFF_CONSOLE && we_i[0];
  jedro_1_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .pop_i   (cons_ready_i),
    .wdata_i (wdata_i[7:0]),
    .rdata_o (cons_data_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign cons_valid_o = !empty;
  // full is the registered occupancy, so a push in the same cycle as a pop still errors when full
  assign cons_err = push && full;
  assign cons_st  = 32'({full, empty, count[CNT_W-1:0]});
  assign last_off = OFF_CONSOLE;
`else
  logic unused_cons;
  assign unused_cons  = cons_ready_i;
  assign cons_valid_o = 1'b0;
  assign cons_data_o  = '0;
  assign cons_err     = 1'b0;
  assign cons_st      = '0;
  assign last_off     = OFF_CYCLE_HI;
`endif
  assign err_c = !hit || off > last_off || cons_err ||
                 (!rd && (off == OFF_CYCLE_LO || off == OFF_CYCLE_HI));
  assign rd_c = off == OFF_SIG_START ? sig_start_o :
                off == OFF_SIG_END   ? sig_end_o :
                off == OFF_HALT      ? 32'(halt_o) << HALT_BIT :
                off == OFF_CYCLE_LO  ? cycle_q[31:0] :
                off == OFF_CYCLE_HI  ? snap_q :
                off == OFF_CONSOLE   ? cons_st : '0;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_o     <= '0;
      rvalid_o    <= 1'b0;
      wvalid_o    <= 1'b0;
      err_o       <= 1'b0;
      halt_o      <= 1'b0;
      sig_start_o <= '0;
      sig_end_o   <= '0;
      snap_q      <= '0;
      cycle_q     <= '0;
    end else begin
      rvalid_o <= req_i && rd;
      wvalid_o <= req_i && !rd;
      err_o    <= req_i && err_c;
      rdata_o  <= (req_i && rd && !err_c) ? rd_c : '0;
      if (wr && off == OFF_SIG_START) sig_start_o <= apply_be(sig_start_o, wdata_i, we_i);
      if (wr && off == OFF_SIG_END) sig_end_o <= apply_be(sig_end_o, wdata_i, we_i);
      if (wr && off == OFF_HALT && we_i[HALT_BIT] && wdata_i[HALT_BIT]) halt_o <= 1'b1;
      // LO read latches the upper word so a following HI read is coherent with it
      if (req_i && hit && rd && off == OFF_CYCLE_LO) snap_q <= cycle_q[63:32];
      if (!halt_o) cycle_q <= cycle_q + 64'd1;
    end
  end
endmodule

// File: tb/tb_jedro_1_test_ctrl.sv
// tb_jedro_1_test_ctrl: scoreboard bench for the jedro_1 test-control responder
module tb_jedro_1_test_ctrl;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  logic clk = 1'b0;
  logic rstn_i = 1'b0, req_i = 1'b0, cons_ready_i = 1'b0;
  logic [3:0] we_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [31:0] rdata_o, sig_start_o, sig_end_o;
  logic rvalid_o, wvalid_o, err_o, halt_o, cons_valid_o;
  logic [7:0] cons_data_o;

  jedro_1_test_ctrl dut (
    .clk_i(clk), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .wvalid_o(wvalid_o),
    .err_o(err_o), .halt_o(halt_o), .sig_start_o(sig_start_o), .sig_end_o(sig_end_o),
    .cons_valid_o(cons_valid_o), .cons_data_o(cons_data_o), .cons_ready_i(cons_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic        err;
    logic [31:0] rdata;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int cyc = 0, checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check({e.tag, ".rvalid"}, rvalid_o, e.is_rd);
      check({e.tag, ".wvalid"}, wvalid_o, !e.is_rd);
      check({e.tag, ".err"}, err_o, e.err);
      check({e.tag, ".rdata"}, rdata_o, e.rdata);
    end else begin
      check("idle", {rvalid_o, wvalid_o, err_o, rdata_o != 0}, 0);
    end
  end

  task automatic send(input string tag, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic err, input logic [31:0] rd);
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    sb.push_back('{we == 0, err, rd, cyc + 1, tag});
    @(posedge clk);
    #1 req_i = 1'b0; we_i = '0;
  endtask

  task automatic preload(input logic [63:0] v);
    @(negedge clk);
    force dut.cycle_q = v;
    #1 release dut.cycle_q;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst.halt", halt_o, 0);
    check("rst.sig_start", sig_start_o, 0);
    check("rst.sig_end", sig_end_o, 0);
    check("rst.cons_valid", cons_valid_o, 0);
    check("rst.cons_data", cons_data_o, 0);
    rstn_i = 1'b1;
    send("hi_rst", 4'h0, BASE + 32'h10, 0, 0, 0);
    send("ss_wr", 4'hF, BASE, 32'h8000_1000, 0, 0);
    @(negedge clk);
    check("sig_start", sig_start_o, 32'h8000_1000);
    send("ss_rd", 4'h0, BASE, 0, 0, 32'h8000_1000);
    send("ss_rd_lsb", 4'h0, BASE + 32'h3, 0, 0, 32'h8000_1000);
    send("se_wr1", 4'b0010, BASE + 32'h4, 32'hAABB_CCDD, 0, 0);
    @(negedge clk);
    check("sig_end1", sig_end_o, 32'h0000_CC00);
    send("se_wr2", 4'b1000, BASE + 32'h4, 32'hAABB_CCDD, 0, 0);
    send("se_rd", 4'h0, BASE + 32'h4, 0, 0, 32'hAA00_CC00);
    send("miss_rd", 4'h0, 32'h0000_0000, 0, 1, 0);
    send("miss_wr", 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1, 0);
    send("miss_edge", 4'hF, 32'hFFFF_FE04, 32'hDEAD_BEEF, 1, 0);
    send("lo_wr", 4'hF, BASE + 32'h0C, 32'h1234, 1, 0);
    send("hi_wr", 4'hF, BASE + 32'h10, 32'h1234, 1, 0);
    send("unmap_rd", 4'h0, BASE + 32'h18, 0, 1, 0);
    send("unmap_wr", 4'hF, BASE + 32'hFC, 32'h1, 1, 0);
    @(negedge clk);
    check("err.sig_start", sig_start_o, 32'h8000_1000);
    check("err.sig_end", sig_end_o, 32'hAA00_CC00);
    send("halt_nolane", 4'b1110, BASE + 32'h8, 32'hFFFF_FFFF, 0, 0);
    @(negedge clk);
    check("halt_nolane", halt_o, 0);
    send("halt_rd0", 4'h0, BASE + 32'h8, 0, 0, 0);
    preload(64'h0000_0005_FFFF_FFFE);
    send("snap_lo", 4'h0, BASE + 32'h0C, 0, 0, 32'hFFFF_FFFF);
    send("snap_hi", 4'h0, BASE + 32'h10, 0, 0, 32'h0000_0005);
    send("snap_lo2", 4'h0, BASE + 32'h0C, 0, 0, 32'h0000_0001);
    send("snap_hi2", 4'h0, BASE + 32'h10, 0, 0, 32'h0000_0006);
    preload(64'hFFFF_FFFF_FFFF_FFFE);
    send("wrap_lo1", 4'h0, BASE + 32'h0C, 0, 0, 32'hFFFF_FFFF);
    send("wrap_lo2", 4'h0, BASE + 32'h0C, 0, 0, 32'h0000_0000);
    send("wrap_hi", 4'h0, BASE + 32'h10, 0, 0, 32'h0000_0000);
`ifdef JEDRO_1_TEST_CTRL_CONSOLE_EN
    send("cs_empty", 4'h0, BASE + 32'h14, 0, 0, 32'h08);
    send("cs_nolane", 4'b0010, BASE + 32'h14, 32'h77, 0, 0);
    send("cs_empty2", 4'h0, BASE + 32'h14, 0, 0, 32'h08);
    @(negedge clk);
    req_i = 1'b1; we_i = 4'b0001; addr_i = BASE + 32'h14; wdata_i = 32'h41;
    sb.push_back('{1'b0, 1'b0, 32'h0, cyc + 1, "push0"});
    #1 check("nobypass", cons_valid_o, 0);
    @(posedge clk);
    #1 req_i = 1'b0; we_i = '0;
    @(negedge clk);
    check("push_visible", cons_valid_o, 1);
    for (int i = 1; i < 9; i++)
      send($sformatf("push%0d", i), 4'b0001, BASE + 32'h14, 32'h41 + i, i == 8, 0);
    send("cs_full", 4'h0, BASE + 32'h14, 0, 0, 32'h10);
    @(negedge clk);
    cons_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d.valid", i), cons_valid_o, 1);
      check($sformatf("drain%0d.data", i), cons_data_o, 8'h41 + i);
      @(negedge clk);
    end
    check("drained.valid", cons_valid_o, 0);
    cons_ready_i = 1'b0;
    send("cs_empty3", 4'h0, BASE + 32'h14, 0, 0, 32'h08);
    send("cs_prerst", 4'b0001, BASE + 32'h14, 32'h5A, 0, 0);
    @(negedge clk);
    check("cs_prerst.valid", cons_valid_o, 1);
`else
    send("cs_rd_dis", 4'h0, BASE + 32'h14, 0, 1, 0);
    send("cs_wr_dis", 4'b0001, BASE + 32'h14, 32'h41, 1, 0);
    @(negedge clk);
    cons_ready_i = 1'b1;
    @(negedge clk);
    check("cs_dis.valid", cons_valid_o, 0);
    check("cs_dis.data", cons_data_o, 0);
    cons_ready_i = 1'b0;
`endif
    preload(64'h0000_0123_0000_0010);
    send("halt_set", 4'b0001, BASE + 32'h8, 32'h1, 0, 0);
    @(negedge clk);
    check("halt_set", halt_o, 1);
    send("halt_lo1", 4'h0, BASE + 32'h0C, 0, 0, 32'h0000_0012);
    repeat (10) @(negedge clk);
    send("halt_lo2", 4'h0, BASE + 32'h0C, 0, 0, 32'h0000_0012);
    send("halt_hi", 4'h0, BASE + 32'h10, 0, 0, 32'h0000_0123);
    send("halt_clr", 4'hF, BASE + 32'h8, 32'h0, 0, 0);
    @(negedge clk);
    check("halt_sticky", halt_o, 1);
    send("halt_rd1", 4'h0, BASE + 32'h8, 0, 0, 32'h1);
    @(negedge clk);
    req_i = 1'b1; we_i = 4'h0; addr_i = BASE + 32'h8;
    @(posedge clk);
    #1 rstn_i = 1'b0; req_i = 1'b0;
    @(negedge clk);
    check("mid_rst.halt", halt_o, 0);
    check("mid_rst.sig_start", sig_start_o, 0);
    check("mid_rst.cons_valid", cons_valid_o, 0);
    @(negedge clk);
    rstn_i = 1'b1;
    send("cyc_after_rst", 4'h0, BASE + 32'h0C, 0, 0, 32'h1);
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
